// File: rtl/elevator_shaft_model.sv
// rtl/elevator_shaft_model.sv - 5-floor elevator car/shaft plant model driven by motor and door commands
// Position is a tick counter; sensors, floor, arrive and moving are all derived from the next position.
module elevator_shaft_model #(
  parameter int FLOOR_TICKS = 4,
  parameter int START_FLOOR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] AC,
  input  logic       Open,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       S4,
  output logic       S5,
  output logic [2:0] floor,
  output logic [7:0] pos,
  output logic       moving,
  output logic       arrive,
  output logic [2:0] fault
);

  localparam logic [7:0] POS_TOP   = 8'(4 * FLOOR_TICKS);
  localparam logic [7:0] POS_RST   = 8'((START_FLOOR - 1) * FLOOR_TICKS);
  localparam logic [2:0] FLOOR_RST = 3'(START_FLOOR);
  localparam logic [4:0] SENS_RST  = 5'(1 << (START_FLOOR - 1));

  logic [7:0] pos_q, pos_d;
  logic [2:0] floor_q, floor_d;
  logic [4:0] sens_q, sens_d;
  logic [2:0] fault_q, fault_d;
  logic       moving_q, moving_d;
  logic       arrive_q, arrive_d;

  always_comb begin
    pos_d   = pos_q;
    fault_d = fault_q;
    // Motion is only applied when no higher-priority fault condition holds.
    if (AC == 2'd3) begin
      fault_d[0] = 1'b1;
    end else if (AC != 2'd0 && Open) begin
      fault_d[1] = 1'b1;
    end else if (AC == 2'd1 && pos_q == POS_TOP) begin
      fault_d[2] = 1'b1;
    end else if (AC == 2'd2 && pos_q == 8'd0) begin
      fault_d[2] = 1'b1;
    end else if (AC == 2'd1) begin
      pos_d = pos_q + 8'd1;
    end else if (AC == 2'd2) begin
      pos_d = pos_q - 8'd1;
    end
  end

  always_comb begin
    sens_d  = 5'b0;
    floor_d = floor_q;
    for (int i = 0; i < 5; i++) begin
      if (pos_d == 8'(i * FLOOR_TICKS)) begin
        sens_d[i] = 1'b1;
        floor_d   = 3'(i + 1);
      end
    end
    moving_d = (pos_d != pos_q);
    // sens_q is nonzero exactly when the old position was aligned.
    arrive_d = (|sens_d) && !(|sens_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q    <= POS_RST;
      floor_q  <= FLOOR_RST;
      sens_q   <= SENS_RST;
      fault_q  <= 3'b000;
      moving_q <= 1'b0;
      arrive_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      floor_q  <= floor_d;
      sens_q   <= sens_d;
      fault_q  <= fault_d;
      moving_q <= moving_d;
      arrive_q <= arrive_d;
    end
  end

  assign S1     = sens_q[0];
  assign S2     = sens_q[1];
  assign S3     = sens_q[2];
  assign S4     = sens_q[3];
  assign S5     = sens_q[4];
  assign floor  = floor_q;
  assign pos    = pos_q;
  assign moving = moving_q;
  assign arrive = arrive_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_elevator_shaft_model.sv
// tb/tb_elevator_shaft_model.sv - directed and randomized bench for elevator_shaft_model
// Reference model tracks an integer car position and derives floor/sensors by division.
module tb_elevator_shaft_model;

  localparam int FT = 4;
  localparam int SF = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] AC = 2'd0;
  logic       Open = 1'b0;
  logic       S1, S2, S3, S4, S5;
  logic [2:0] floor;
  logic [7:0] pos;
  logic       moving, arrive;
  logic [2:0] fault;

  int tests_run = 0;
  int tests_failed = 0;

  int       m_pos = 0;
  int       m_floor = SF;
  logic [2:0] m_fault = 3'b000;
  logic     m_moving = 1'b0;
  logic     m_arrive = 1'b0;

  elevator_shaft_model #(.FLOOR_TICKS(FT), .START_FLOOR(SF)) dut (
    .clk(clk), .rst(rst), .AC(AC), .Open(Open),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5),
    .floor(floor), .pos(pos), .moving(moving), .arrive(arrive), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs_s();
    return {S5, S4, S3, S2, S1};
  endfunction

  function automatic logic [4:0] exp_s();
    if (m_pos % FT == 0) return 5'(1 << (m_pos / FT));
    return 5'b0;
  endfunction

  // Drive one edge and advance the reference model; outputs sampled 1 time unit after the edge.
  task automatic step(input logic [1:0] ac, input logic op, input logic r);
    int old;
    AC = ac; Open = op; rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_pos = (SF - 1) * FT; m_floor = SF; m_fault = 3'b000;
      m_moving = 1'b0; m_arrive = 1'b0;
    end else begin
      old = m_pos;
      if (ac == 2'd3) m_fault[0] = 1'b1;
      else if (ac != 2'd0 && op) m_fault[1] = 1'b1;
      else if (ac == 2'd1 && m_pos == 4 * FT) m_fault[2] = 1'b1;
      else if (ac == 2'd2 && m_pos == 0) m_fault[2] = 1'b1;
      else if (ac == 2'd1) m_pos++;
      else if (ac == 2'd2) m_pos--;
      m_moving = (m_pos != old);
      m_arrive = (m_pos % FT == 0) && (old % FT != 0);
      if (m_pos % FT == 0) m_floor = m_pos / FT + 1;
    end
  endtask

  task automatic do_reset();
    step(2'd0, 1'b0, 1'b1);
    step(2'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (obs_s() !== 5'b00001) begin tests_failed++; $display("FAIL reset_s got %b want %b", obs_s(), 5'b00001); end
    tests_run++;
    if (floor !== 3'd1) begin tests_failed++; $display("FAIL reset_floor got %0d want 1", floor); end
    tests_run++;
    if (pos !== 8'd0) begin tests_failed++; $display("FAIL reset_pos got %0d want 0", pos); end
    tests_run++;
    if ({fault, moving, arrive} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags got %b want 00000", {fault, moving, arrive}); end
  endtask

  task automatic test_up_one_floor();
    do_reset();
    step(2'd1, 1'b0, 1'b0);
    tests_run++;
    if ({pos, S1, moving, arrive} !== {8'd1, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL up_edge1 got pos=%0d S1=%b mv=%b arr=%b want 1 0 1 0", pos, S1, moving, arrive);
    end
    for (int i = 0; i < 3; i++) step(2'd1, 1'b0, 1'b0);
    tests_run++;
    if ({pos, obs_s(), floor, arrive} !== {8'd4, 5'b00010, 3'd2, 1'b1}) begin
      tests_failed++; $display("FAIL up_edge4 got pos=%0d s=%b fl=%0d arr=%b want 4 00010 2 1", pos, obs_s(), floor, arrive);
    end
    step(2'd0, 1'b0, 1'b0);
    tests_run++;
    if ({arrive, moving, S2} !== 3'b001) begin
      tests_failed++; $display("FAIL up_stop got arr=%b mv=%b S2=%b want 0 0 1", arrive, moving, S2);
    end
  endtask

  task automatic test_top_limit();
    do_reset();
    for (int i = 0; i < 16; i++) step(2'd1, 1'b0, 1'b0);
    tests_run++;
    if ({pos, obs_s(), floor} !== {8'd16, 5'b10000, 3'd5}) begin
      tests_failed++; $display("FAIL top_reach got pos=%0d s=%b fl=%0d want 16 10000 5", pos, obs_s(), floor);
    end
    step(2'd1, 1'b0, 1'b0);
    tests_run++;
    if ({pos, fault[2], moving} !== {8'd16, 1'b1, 1'b0}) begin
      tests_failed++; $display("FAIL top_overtravel got pos=%0d f2=%b mv=%b want 16 1 0", pos, fault[2], moving);
    end
  endtask

  task automatic test_reversal();
    do_reset();
    for (int i = 0; i < 8; i++) step(2'd1, 1'b0, 1'b0);
    step(2'd1, 1'b0, 1'b0);
    step(2'd1, 1'b0, 1'b0);
    tests_run++;
    if ({pos, obs_s()} !== {8'd10, 5'b00000}) begin
      tests_failed++; $display("FAIL rev_midspan got pos=%0d s=%b want 10 00000", pos, obs_s());
    end
    step(2'd2, 1'b0, 1'b0);
    step(2'd2, 1'b0, 1'b0);
    tests_run++;
    if ({pos, obs_s(), arrive, fault} !== {8'd8, 5'b00100, 1'b1, 3'b000}) begin
      tests_failed++; $display("FAIL rev_back got pos=%0d s=%b arr=%b f=%b want 8 00100 1 000", pos, obs_s(), arrive, fault);
    end
  endtask

  task automatic test_interlock();
    do_reset();
    for (int i = 0; i < 4; i++) step(2'd1, 1'b0, 1'b0);
    step(2'd2, 1'b1, 1'b0);
    tests_run++;
    if ({pos, S2, fault} !== {8'd4, 1'b1, 3'b010}) begin
      tests_failed++; $display("FAIL interlock got pos=%0d S2=%b f=%b want 4 1 010", pos, S2, fault);
    end
    step(2'd3, 1'b0, 1'b0);
    tests_run++;
    if (fault !== 3'b011) begin tests_failed++; $display("FAIL illegal_ac got f=%b want 011", fault); end
  endtask

  task automatic test_reset_mid_span();
    do_reset();
    for (int i = 0; i < 6; i++) step(2'd1, 1'b0, 1'b0);
    step(2'd3, 1'b0, 1'b0);
    step(2'd1, 1'b0, 1'b1);
    tests_run++;
    if ({pos, S1, floor, fault, arrive} !== {8'd0, 1'b1, 3'd1, 3'b000, 1'b0}) begin
      tests_failed++; $display("FAIL reset_mid got pos=%0d S1=%b fl=%0d f=%b arr=%b want 0 1 1 000 0", pos, S1, floor, fault, arrive);
    end
  endtask

  task automatic test_random();
    logic [1:0] ac;
    logic op, r;
    int dir;
    do_reset();
    dir = 1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) dir = $urandom_range(0, 2);
      ac = 2'(dir);
      op = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 39) == 0) ac = 2'd3;
      r = ($urandom_range(0, 199) == 0);
      step(ac, op, r);
      tests_run++;
      if ({obs_s(), floor, pos, moving, arrive, fault} !==
          {exp_s(), 3'(m_floor), 8'(m_pos), m_moving, m_arrive, m_fault}) begin
        tests_failed++;
        $display("FAIL rand[%0d] got s=%b fl=%0d pos=%0d mv=%b arr=%b f=%b want s=%b fl=%0d pos=%0d mv=%b arr=%b f=%b",
                 n, obs_s(), floor, pos, moving, arrive, fault,
                 exp_s(), m_floor, m_pos, m_moving, m_arrive, m_fault);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_one_floor();
    test_top_limit();
    test_reversal();
    test_interlock();
    test_reset_mid_span();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
